// File: rtl/real_pow_pkg.sv
// rtl/real_pow_pkg.sv - shared constants and helpers for the real power pipeline
// Purpose: default clamp/tolerance constants and the integer-exponent test
//          used by every real_pow_lane instance.
// Ports:   none (package)
package real_pow_pkg;

    localparam real REAL_POW_OUT_MAX = 1.0e30;
    localparam real REAL_POW_INT_TOL = 1.0e-12;

    // True when x lies within tol of the nearest integer.
    function automatic logic is_int_real(input real x, input real tol);
        real d;
        d = x - $floor(x + 0.5);
        return (d <= tol) && (d >= -tol);
    endfunction

endpackage

// File: rtl/real_pow_lane.sv
// rtl/real_pow_lane.sv - combinational single-lane real power with domain checking
// Purpose: o_r = i_base ** i_powf with clamping and a domain/overflow flag.
// Ports:   i_base, i_powf : operands
//          o_r            : result (clamped to +/-OUT_MAX, 0.0 on invalid domain)
//          o_err          : domain or overflow flag
module real_pow_lane
    import real_pow_pkg::*;
#(
    parameter real OUT_MAX = REAL_POW_OUT_MAX,
    parameter real INT_TOL = REAL_POW_INT_TOL
) (
    input  real  i_base,
    input  real  i_powf,
    output real  o_r,
    output logic o_err
);

    real w_rp;
    real w_pw;

    always_comb begin
        w_rp  = $floor(i_powf + 0.5);
        w_pw  = 0.0;
        o_r   = 0.0;
        o_err = 1'b0;
        if (i_base < 0.0 && !is_int_real(i_powf, INT_TOL)) begin
            o_err = 1'b1;
        end else if (i_base == 0.0 && i_powf < 0.0) begin
            o_r   = OUT_MAX;
            o_err = 1'b1;
        end else begin
            // Negative base: use the rounded exponent so a near-integer
            // exponent cannot produce NaN; the sign follows its parity.
            if (i_base < 0.0) begin
                w_pw = (-i_base) ** w_rp;
                if ($floor(w_rp * 0.5) * 2.0 != w_rp) begin
                    w_pw = -w_pw;
                end
            end else begin
                w_pw = i_base ** i_powf;
            end
            if (w_pw != w_pw) begin
                o_err = 1'b1;
            end else if (w_pw > OUT_MAX) begin
                o_r   = OUT_MAX;
                o_err = 1'b1;
            end else if (w_pw < -OUT_MAX) begin
                o_r   = -OUT_MAX;
                o_err = 1'b1;
            end else begin
                o_r = w_pw;
            end
        end
    end

endmodule

// File: rtl/real_pow_pipe.sv
// rtl/real_pow_pipe.sv - multi-lane stallable real power pipeline
// Purpose: o_out[i] = i_in[i] ** i_powf[i] through LAT register stages with a
//          valid/ready handshake and per-lane error flags.
// Ports:   i_clk, i_rst              : clock, synchronous active-high reset
//          i_in_valid, o_in_ready    : input handshake
//          i_in, i_powf              : per-lane base / exponent
//          o_out_valid, i_out_ready  : output handshake
//          o_out, o_err              : per-lane result and flag
//          o_n_done, o_n_err         : delivery / error-lane counters
//                                      (only with DAVE_REAL_POW_STAT_EN)
module real_pow_pipe
    import real_pow_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  LAT     = 3,
    parameter real OUT_MAX = REAL_POW_OUT_MAX,
    parameter real INT_TOL = REAL_POW_INT_TOL
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  real            i_in   [NCH],
    input  real            i_powf [NCH],
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output real            o_out  [NCH],
    output logic [NCH-1:0] o_err
`ifdef DAVE_REAL_POW_STAT_EN
    ,
    output logic [31:0]    o_n_done,
    output logic [31:0]    o_n_err
`endif
);

    real            w_r [NCH];
    logic [NCH-1:0] w_err;
    logic           w_adv;

    logic [LAT-1:0] r_vld;
    logic [NCH-1:0] r_err [LAT];
    real            r_dat [LAT][NCH];

    // Global stall: the whole pipe moves only when the last stage is free.
    assign w_adv       = !o_out_valid || i_out_ready;
    assign o_in_ready  = w_adv;
    assign o_out_valid = r_vld[LAT-1];
    assign o_err       = r_err[LAT-1];

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        real_pow_lane #(
            .OUT_MAX (OUT_MAX),
            .INT_TOL (INT_TOL)
        ) u_lane (
            .i_base (i_in[g]),
            .i_powf (i_powf[g]),
            .o_r    (w_r[g]),
            .o_err  (w_err[g])
        );
        assign o_out[g] = r_dat[LAT-1][g];
    end

    // Data/err only move with a valid beat so bubbles leave the last
    // delivered result visible at the output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_err[s] <= '0;
                for (int l = 0; l < NCH; l++) begin
                    r_dat[s][l] <= 0.0;
                end
            end
        end else if (w_adv) begin
            r_vld[0] <= i_in_valid;
            if (i_in_valid) begin
                r_err[0] <= w_err;
                for (int l = 0; l < NCH; l++) begin
                    r_dat[0][l] <= w_r[l];
                end
            end
            for (int s = 1; s < LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_err[s] <= r_err[s-1];
                    for (int l = 0; l < NCH; l++) begin
                        r_dat[s][l] <= r_dat[s-1][l];
                    end
                end
            end
        end
    end

`ifdef DAVE_REAL_POW_STAT_EN
    logic [31:0] r_n_done;
    logic [31:0] r_n_err;
    logic [32:0] w_err_sum;

    assign w_err_sum = {1'b0, r_n_err} + 33'($countones(r_err[LAT-1]));
    assign o_n_done  = r_n_done;
    assign o_n_err   = r_n_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n_done <= '0;
            r_n_err  <= '0;
        end else if (o_out_valid && i_out_ready) begin
            if (r_n_done != 32'hFFFF_FFFF) begin
                r_n_done <= r_n_done + 32'd1;
            end
            r_n_err <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        end
    end
`endif

endmodule
